// File: rtl/fptd_ctrl_pkg.sv
// ----------------------------------------------------------------
// fptd_ctrl_pkg : shared types and defaults for the FPTD razor scheduler
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package fptd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EVAL   = 3'd1,
    CHECK  = 3'd2,
    REPLAY = 3'd3,
    DONE   = 3'd4
  } sched_state_t;

  localparam int NSEC_DEFAULT      = 8;
  localparam int RETRY_MAX_DEFAULT = 3;
  localparam int CNT_W_DEFAULT     = 8;

endpackage

`default_nettype wire

// File: rtl/fptd_sat_counter.sv
// ----------------------------------------------------------------
// fptd_sat_counter : clearable up-counter that sticks at all-ones
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module fptd_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fptd_razor_sched.sv
// ----------------------------------------------------------------
// fptd_razor_sched : EVAL/CHECK/REPLAY half-iteration scheduler
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module fptd_razor_sched
  import fptd_ctrl_pkg::*;
#(
  parameter int NSEC      = NSEC_DEFAULT,
  parameter int ITER_W    = 6,
  parameter int RETRY_MAX = RETRY_MAX_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ITER_W-1:0] NumIter,
  input  logic [NSEC-1:0]   Error_section,
  output logic              Enable,
  output logic              Phase,
  output logic              Hold,
  output logic              Busy,
  output logic              Done,
  output logic              Fail,
  output logic [CNT_W-1:0]  ErrCount
);

  localparam int RETRY_W = $clog2(RETRY_MAX + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  sched_state_t          state;
  sched_state_t          state_next;
  logic [ITER_W-1:0]     num_iter;
  logic [ITER_W:0]       half_cnt;
  logic [ITER_W:0]       last_half;
  logic [RETRY_W-1:0]    retry;
  logic                  err;
  logic                  can_retry;
  logic                  is_last;
  logic                  start_ok;

  assign err       = |Error_section;
  assign can_retry = retry < RETRY_LIM;
  // One extra bit keeps 2*NumIter-1 from wrapping at the largest NumIter.
  assign last_half = {num_iter, 1'b0} - (ITER_W+1)'(1);
  assign is_last   = half_cnt == last_half;
  assign start_ok  = (state == IDLE) && Start;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = (NumIter == '0) ? DONE : EVAL;
        end
      end
      EVAL:   state_next = CHECK;
      CHECK: begin
        if (err && can_retry) begin
          state_next = REPLAY;
        end else if (is_last) begin
          state_next = DONE;
        end else begin
          state_next = EVAL;
        end
      end
      REPLAY: state_next = EVAL;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Enable = 1'b0;
    Hold   = 1'b0;
    Done   = 1'b0;
    Busy   = 1'b1;
    case (state)
      IDLE:   Busy   = 1'b0;
      EVAL:   Enable = 1'b1;
      REPLAY: Hold   = 1'b1;
      DONE:   Done   = 1'b1;
      default: ;
    endcase
  end

  // Frame bookkeeping: progress only advances out of CHECK, either clean or out of retries.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      num_iter <= '0;
      half_cnt <= '0;
      retry    <= '0;
      Phase    <= 1'b0;
      Fail     <= 1'b0;
    end else if (start_ok) begin
      num_iter <= NumIter;
      half_cnt <= '0;
      retry    <= '0;
      Phase    <= 1'b0;
      Fail     <= 1'b0;
    end else if (state == CHECK) begin
      if (err && can_retry) begin
        retry <= retry + RETRY_W'(1);
      end else begin
        retry <= '0;
        if (err) begin
          Fail <= 1'b1;
        end
        if (!is_last) begin
          half_cnt <= half_cnt + (ITER_W+1)'(1);
          Phase    <= ~Phase;
        end
      end
    end
  end

  fptd_sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (Clock),
    .rst   (Reset),
    .clear (start_ok),
    .inc   ((state == CHECK) && err),
    .count (ErrCount)
  );

endmodule

`default_nettype wire

// File: tb/tb_fptd_razor_sched.sv
// ----------------------------------------------------------------
// tb_fptd_razor_sched : scoreboard bench for the razor scheduler
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_fptd_razor_sched;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [5:0] NumIter = '0;
  logic [7:0] Error_section = '0;

  logic       Enable, Phase, Hold, Busy, Done, Fail;
  logic [7:0] ErrCount;
  logic       Enable2, Phase2, Hold2, Busy2, Done2, Fail2;
  logic [1:0] ErrCount2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       en;
    logic       ph;
    logic       hold;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [7:0] err;
  } rec_t;

  rec_t exp_q[$];

  fptd_razor_sched dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .NumIter(NumIter),
    .Error_section(Error_section), .Enable(Enable), .Phase(Phase),
    .Hold(Hold), .Busy(Busy), .Done(Done), .Fail(Fail), .ErrCount(ErrCount)
  );

  fptd_razor_sched #(.CNT_W(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .NumIter(NumIter),
    .Error_section(Error_section), .Enable(Enable2), .Phase(Phase2),
    .Hold(Hold2), .Busy(Busy2), .Done(Done2), .Fail(Fail2), .ErrCount(ErrCount2)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic en, input logic ph, input logic hold, input logic busy,
                      input logic done, input logic fl, input int c, input int c2,
                      input logic [7:0] e);
    rec_t r;
    r.en = en; r.ph = ph; r.hold = hold; r.busy = busy; r.done = done; r.fail = fl;
    r.cnt = 8'(c); r.cnt2 = 2'(c2); r.err = e;
    exp_q.push_back(r);
  endtask

  // Reference cycle trace. mode: 0 clean, 1 error on first CHECK only,
  // 2 error on every CHECK of half-iteration 0, 3 error on every CHECK.
  task automatic build(input int n, input int mode);
    logic ph = 1'b0;
    logic fl = 1'b0;
    int   c = 0, c2 = 0, retry;
    logic e, again;
    for (int h = 0; h < 2*n; h++) begin
      retry = 0;
      again = 1'b1;
      while (again) begin
        push(1, ph, 0, 1, 0, fl, c, c2, 8'hFF);
        e = (mode == 3) || (mode == 2 && h == 0) || (mode == 1 && h == 0 && retry == 0);
        push(0, ph, 0, 1, 0, fl, c, c2, e ? 8'h04 : 8'h00);
        again = 1'b0;
        if (e) begin
          c  = (c  < 255) ? c + 1  : 255;
          c2 = (c2 < 3)   ? c2 + 1 : 3;
          if (retry < 3) begin
            retry++;
            push(0, ph, 1, 1, 0, fl, c, c2, 8'hFF);
            again = 1'b1;
          end else begin
            fl = 1'b1;
          end
        end
      end
      if (h != 2*n-1) ph = ~ph;
    end
    push(0, ph, 0, 1, 1, fl, c, c2, 8'hFF);
    push(0, ph, 0, 0, 0, fl, c, c2, 8'h00);
  endtask

  task automatic check_rec(input rec_t r, input int cyc);
    chk($sformatf("enable c%0d", cyc), Enable, r.en);
    chk($sformatf("phase c%0d", cyc), Phase, r.ph);
    chk($sformatf("hold c%0d", cyc), Hold, r.hold);
    chk($sformatf("busy c%0d", cyc), Busy, r.busy);
    chk($sformatf("done c%0d", cyc), Done, r.done);
    chk($sformatf("fail c%0d", cyc), Fail, r.fail);
    chk($sformatf("errcount c%0d", cyc), ErrCount, r.cnt);
    chk($sformatf("errcount_w2 c%0d", cyc), ErrCount2, r.cnt2);
    chk($sformatf("fail_w2 c%0d", cyc), Fail2, r.fail);
  endtask

  // Drives one frame; limit<0 runs it to completion, otherwise stops after that many cycles.
  task automatic run(input int n, input int mode, input int limit);
    rec_t r;
    int   cyc = 0;
    build(n, mode);
    @(negedge Clock);
    Start = 1'b1;
    NumIter = 6'(n);
    Error_section = '0;
    while (exp_q.size() > 0 && (limit < 0 || cyc < limit)) begin
      @(negedge Clock);
      cyc++;
      r = exp_q.pop_front();
      check_rec(r, cyc);
      Start = r.busy ? 1'($urandom_range(0, 1)) : 1'b0;
      NumIter = 6'($urandom_range(0, 63));
      Error_section = r.err;
    end
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " enable"}, Enable, 0);
    chk({tag, " phase"}, Phase, 0);
    chk({tag, " hold"}, Hold, 0);
    chk({tag, " busy"}, Busy, 0);
    chk({tag, " done"}, Done, 0);
    chk({tag, " fail"}, Fail, 0);
    chk({tag, " errcount"}, ErrCount, 0);
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    check_zero("reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    check_zero("idle");

    run(2, 0, -1);
    run(1, 1, -1);
    run(1, 2, -1);
    run(2, 3, -1);
    // Fail and both counters must hold in IDLE until the next Start.
    repeat (3) @(negedge Clock);
    chk("fail sticky", Fail, 1);
    chk("errcount hold", ErrCount, 8'd16);
    chk("errcount_w2 sat", ErrCount2, 2'd3);
    run(0, 0, -1);

    // Asynchronous reset in cycle 4 of a 3-iteration frame.
    run(3, 0, 3);
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1 check_zero("midreset");
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      chk("post_reset done", Done, 0);
      chk("post_reset busy", Busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
